ub_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single unified-buffer (UB) SRAM port between the DMA engine, the systolic-array input reader and the VPU writeback path. Each requester asks for a burst of consecutive UB words. The arbiter grants one burst at a time, drives the UB port for every beat, and returns read data with a per-requester valid strobe. It sits between the datapath units and the UB macro. The TPU controller's stall logic can freeze new grants through `arb_hold` and observe `ub_busy`.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/ub_port_arbiter.sv | 116 +++++++++++
 tb/tb_ub_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: unified-buffer arbiter states and requester indices.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ZERO  = 2'd2
  } ub_arb_state_t;

  localparam int REQ_DMA = 0;
  localparam int REQ_SYS = 1;
  localparam int REQ_VPU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int w_idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!any && req[w_idx]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ub_port_arbiter.sv
// Round-robin owner of the single unified-buffer port: grants one burst at a time,
// drives every beat, and returns read strobes one cycle behind each read beat.
module ub_port_arbiter
  import tpu_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic                      arb_hold,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          beat,
  output logic [N_REQ-1:0]          rd_valid,
  output logic                      ub_en,
  output logic                      ub_we,
  output logic [ADDR_W-1:0]         ub_addr,
  output logic [DATA_W-1:0]         ub_wdata,
  input  logic [DATA_W-1:0]         ub_rdata,
  output logic [DATA_W-1:0]         ub_rdata_out,
  output logic                      ub_busy,
  output logic [$clog2(N_REQ)-1:0]  owner
);

  localparam int IDX_W = $clog2(N_REQ);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
    return len;
  endfunction

  ub_arb_state_t     r_state, w_next_state;
  logic [IDX_W-1:0]  r_owner, r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [LEN_W-1:0]  r_rem;
  logic [N_REQ-1:0]  r_rd_valid;

  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_any, w_grant, w_burst, w_last;
  logic [LEN_W-1:0]  w_len_sel;
  logic [N_REQ-1:0]  w_owner_oh;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_grant   = (r_state == ST_IDLE) && !arb_hold && w_any;
  assign w_len_sel = clamp_len(req_len[int'(w_gnt_idx)*LEN_W +: LEN_W]);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next_state = (w_len_sel == '0) ? ST_ZERO : ST_BURST;
      ST_BURST: if (r_rem == LEN_W'(1)) w_next_state = ST_IDLE;
      ST_ZERO:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Control state: cleared asynchronously so an interrupted burst is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_rd_valid <= '0;
    end else begin
      r_state    <= w_next_state;
      r_rd_valid <= (w_burst && !r_write) ? w_owner_oh : '0;
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_ptr   <= (int'(w_gnt_idx) == N_REQ-1) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  // Burst datapath: only observed while in BURST, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr  <= req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
      r_write <= req_write[w_gnt_idx];
      r_rem   <= w_len_sel;
    end else if (w_burst) begin
      r_addr <= r_addr + 1'b1;
      r_rem  <= r_rem - 1'b1;
    end
  end

  assign w_burst    = (r_state == ST_BURST);
  assign w_last     = (w_burst && (r_rem == LEN_W'(1))) || (r_state == ST_ZERO);
  assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  assign beat         = w_burst ? w_owner_oh : '0;
  assign req_ack      = w_last ? w_owner_oh : '0;
  assign rd_valid     = r_rd_valid;
  assign ub_en        = w_burst;
  assign ub_we        = w_burst && r_write;
  assign ub_addr      = w_burst ? r_addr : '0;
  assign ub_wdata     = w_burst ? req_wdata[int'(r_owner)*DATA_W +: DATA_W] : '0;
  assign ub_rdata_out = ub_rdata;
  assign ub_busy      = (r_state != ST_IDLE);
  assign owner        = r_owner;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed bench for ub_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_ub_port_arbiter;
  import tpu_pkg::*;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 5;

  logic                     clk;
  logic                     rst_n;
  logic [N_REQ-1:0]         req_valid, req_write;
  logic [N_REQ*ADDR_W-1:0]  req_addr;
  logic [N_REQ*LEN_W-1:0]   req_len;
  logic [N_REQ*DATA_W-1:0]  req_wdata;
  logic                     arb_hold;
  logic [N_REQ-1:0]         req_ack, beat, rd_valid;
  logic                     ub_en, ub_we, ub_busy;
  logic [ADDR_W-1:0]        ub_addr;
  logic [DATA_W-1:0]        ub_wdata, ub_rdata, ub_rdata_out;
  logic [1:0]               owner;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] wd [N_REQ];

  ub_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .arb_hold(arb_hold),
    .req_ack(req_ack), .beat(beat), .rd_valid(rd_valid), .ub_en(ub_en), .ub_we(ub_we),
    .ub_addr(ub_addr), .ub_wdata(ub_wdata), .ub_rdata(ub_rdata),
    .ub_rdata_out(ub_rdata_out), .ub_busy(ub_busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    req_valid[i] = v;
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_len[i*LEN_W +: LEN_W]    = len;
  endtask

  task automatic drive_wd(input int i);
    req_wdata[i*DATA_W +: DATA_W] = wd[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    arb_hold  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_en"},    64'(ub_en), 64'd0);
    chk({tag, "_beat"},  64'(beat), 64'd0);
    chk({tag, "_ack"},   64'(req_ack), 64'd0);
    chk({tag, "_busy"},  64'(ub_busy), 64'd0);
    chk({tag, "_addr"},  64'(ub_addr), 64'd0);
    chk({tag, "_wdata"}, ub_wdata, 64'd0);
  endtask

  // Checks n beats of a burst of total length len from requester o starting at a0.
  task automatic expect_burst(input string tag, input int o, input logic [ADDR_W-1:0] a0,
                              input int n, input int len, input logic wr, input logic drop);
    logic [N_REQ-1:0]  oh;
    logic [ADDR_W-1:0] a;
    oh = 3'b001 << o;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      a = a0 + ADDR_W'(b);
      chk({tag, "_beat"},  64'(beat), 64'(oh));
      chk({tag, "_owner"}, 64'(owner), 64'(o));
      chk({tag, "_en"},    64'(ub_en), 64'd1);
      chk({tag, "_we"},    64'(ub_we), 64'(wr));
      chk({tag, "_addr"},  64'(ub_addr), 64'(a));
      chk({tag, "_ack"},   64'(req_ack), (b == len-1) ? 64'(oh) : 64'd0);
      chk({tag, "_rdv"},   64'(rd_valid), (b > 0 && !wr) ? 64'(oh) : 64'd0);
      chk({tag, "_busy"},  64'(ub_busy), 64'd1);
      if (wr) begin
        chk({tag, "_wdata"}, ub_wdata, wd[o]);
        wd[o] = wd[o] + 64'd1;
        drive_wd(o);
      end
      if (b == len-1 && drop) req_valid[o] = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_len   = '0;
    arb_hold  = 1'b0;
    ub_rdata  = 64'h0123_4567_89AB_CDEF;
    wd[0] = 64'hA000; wd[1] = 64'hB000; wd[2] = 64'hC000;
    for (int i = 0; i < N_REQ; i++) drive_wd(i);

    // Reset state
    @(negedge clk);
    check_idle("rst");
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rdata_pass", ub_rdata_out, 64'h0123_4567_89AB_CDEF);

    // 1. Single read burst
    do_reset();
    set_req(REQ_DMA, 1'b1, 1'b0, 8'h10, 5'd4);
    expect_burst("rd", REQ_DMA, 8'h10, 4, 4, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("rd_end");
    chk("rd_last_rdv", 64'(rd_valid), 64'b001);
    @(negedge clk);
    chk("rd_rdv_off", 64'(rd_valid), 64'd0);
    ub_rdata = 64'hDEAD_BEEF_0000_1111;
    #1 chk("rdata_pass2", ub_rdata_out, 64'hDEAD_BEEF_0000_1111);

    // 2. Round-robin between three writers
    do_reset();
    set_req(REQ_DMA, 1'b1, 1'b1, 8'h20, 5'd2);
    set_req(REQ_SYS, 1'b1, 1'b1, 8'h40, 5'd2);
    set_req(REQ_VPU, 1'b1, 1'b1, 8'h60, 5'd2);
    expect_burst("rr0", REQ_DMA, 8'h20, 2, 2, 1'b1, 1'b0);
    set_req(REQ_DMA, 1'b1, 1'b1, 8'h30, 5'd2);
    @(negedge clk); check_idle("rr_gap0");
    expect_burst("rr1", REQ_SYS, 8'h40, 2, 2, 1'b1, 1'b1);
    @(negedge clk); check_idle("rr_gap1");
    expect_burst("rr2", REQ_VPU, 8'h60, 2, 2, 1'b1, 1'b1);
    @(negedge clk); check_idle("rr_gap2");
    expect_burst("rr3", REQ_DMA, 8'h30, 2, 2, 1'b1, 1'b1);
    @(negedge clk); check_idle("rr_end");

    // 3. Address wrap, then length clamp
    do_reset();
    set_req(REQ_VPU, 1'b1, 1'b1, 8'hFE, 5'd3);
    expect_burst("wrap", REQ_VPU, 8'hFE, 3, 3, 1'b1, 1'b0);
    set_req(REQ_VPU, 1'b1, 1'b1, 8'h80, 5'd20);
    @(negedge clk); check_idle("wrap_gap");
    expect_burst("clamp", REQ_VPU, 8'h80, 16, 16, 1'b1, 1'b1);
    @(negedge clk); check_idle("clamp_end");

    // 4. Zero-length request, then hold
    do_reset();
    set_req(REQ_SYS, 1'b1, 1'b0, 8'h33, 5'd0);
    @(negedge clk);
    chk("zero_ack",  64'(req_ack), 64'b010);
    chk("zero_en",   64'(ub_en), 64'd0);
    chk("zero_beat", 64'(beat), 64'd0);
    chk("zero_busy", 64'(ub_busy), 64'd1);
    req_valid[REQ_SYS] = 1'b0;
    @(negedge clk);
    check_idle("zero_end");
    chk("zero_rdv", 64'(rd_valid), 64'd0);
    arb_hold = 1'b1;
    set_req(REQ_DMA, 1'b1, 1'b0, 8'h05, 5'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_busy", 64'(ub_busy), 64'd0);
      chk("hold_en", 64'(ub_en), 64'd0);
    end
    arb_hold = 1'b0;
    expect_burst("hold_rel", REQ_DMA, 8'h05, 1, 1, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("hold_end");
    chk("hold_rdv", 64'(rd_valid), 64'b001);

    // 5. Reset in the middle of a burst
    do_reset();
    set_req(REQ_DMA, 1'b1, 1'b0, 8'h50, 5'd8);
    set_req(REQ_SYS, 1'b1, 1'b0, 8'h70, 5'd1);
    expect_burst("pre_rst", REQ_DMA, 8'h50, 3, 8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("mid_rst");
    chk("mid_rst_rdv", 64'(rd_valid), 64'd0);
    chk("mid_rst_we", 64'(ub_we), 64'd0);
    chk("mid_rst_owner", 64'(owner), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_burst("reissue", REQ_DMA, 8'h50, 8, 8, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("reissue_end");
    chk("reissue_rdv", 64'(rd_valid), 64'b001);
    expect_burst("sys_after", REQ_SYS, 8'h70, 1, 1, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
